// File: rtl/cluster_rate_monitor_if.sv
// Bundles the cluster-count stream, control and result signals of the rate monitor.
interface cluster_rate_monitor_if #(
  parameter int unsigned CNT_WIDTH = 11,
  parameter int unsigned WIN_WIDTH = 24,
  parameter int unsigned OVF_WIDTH = 16
);
  logic [CNT_WIDTH-1:0]           cnt;
  logic                           overflow;
  logic                           enable;
  logic                           oneshot;
  logic                           clear;
  logic [WIN_WIDTH-1:0]           window_len;
  logic [CNT_WIDTH+WIN_WIDTH-1:0] sum;
  logic [CNT_WIDTH-1:0]           peak;
  logic [OVF_WIDTH-1:0]           ovf_cnt;
  logic                           done;
  logic                           busy;

  modport master (
    output cnt, overflow, enable, oneshot, clear, window_len,
    input  sum, peak, ovf_cnt, done, busy
  );

  modport slave (
    input  cnt, overflow, enable, oneshot, clear, window_len,
    output sum, peak, ovf_cnt, done, busy
  );
endinterface

// File: rtl/cluster_rate_monitor.sv
// Windowed accumulator of per-cycle cluster counts: publishes sum, peak and saturating
// overflow-cycle count for each completed window, with a one-cycle done strobe.
module cluster_rate_monitor #(
  parameter int unsigned CNT_WIDTH = 11,
  parameter int unsigned WIN_WIDTH = 24,
  parameter int unsigned OVF_WIDTH = 16
) (
  input logic                   clock,
  input logic                   reset_n,
  cluster_rate_monitor_if.slave mon_io
);

  localparam int unsigned SumWidth = CNT_WIDTH + WIN_WIDTH;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   ovf_q;
  logic [WIN_WIDTH-1:0]   len_q, len_d;
  logic [WIN_WIDTH-1:0]   win_cnt_q, win_cnt_d;
  logic [SumWidth-1:0]    acc_sum_q, acc_sum_d;
  logic [CNT_WIDTH-1:0]   acc_peak_q, acc_peak_d;
  logic [OVF_WIDTH-1:0]   acc_ovf_q, acc_ovf_d;
  logic [SumWidth-1:0]    sum_q, sum_d;
  logic [CNT_WIDTH-1:0]   peak_q, peak_d;
  logic [OVF_WIDTH-1:0]   ovf_cnt_q, ovf_cnt_d;
  logic                   done_q, done_d;

  // Accumulator values including the sample currently held in the input register.
  logic [SumWidth-1:0]    samp_sum;
  logic [CNT_WIDTH-1:0]   samp_peak;
  logic [OVF_WIDTH-1:0]   samp_ovf;
  logic [WIN_WIDTH-1:0]   len_in;
  logic                   terminal;

  always_comb begin
    samp_sum  = acc_sum_q + SumWidth'(cnt_q);
    samp_peak = (cnt_q > acc_peak_q) ? cnt_q : acc_peak_q;
    samp_ovf  = (ovf_q && (acc_ovf_q != '1)) ? acc_ovf_q + OVF_WIDTH'(1) : acc_ovf_q;
    len_in    = (mon_io.window_len == '0) ? WIN_WIDTH'(1) : mon_io.window_len;
    terminal  = (win_cnt_q == len_q - WIN_WIDTH'(1));
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    win_cnt_d  = win_cnt_q;
    acc_sum_d  = acc_sum_q;
    acc_peak_d = acc_peak_q;
    acc_ovf_d  = acc_ovf_q;
    sum_d      = sum_q;
    peak_d     = peak_q;
    ovf_cnt_d  = ovf_cnt_q;
    done_d     = 1'b0;

    if (mon_io.clear) begin
      state_d    = StIdle;
      win_cnt_d  = '0;
      acc_sum_d  = '0;
      acc_peak_d = '0;
      acc_ovf_d  = '0;
      sum_d      = '0;
      peak_d     = '0;
      ovf_cnt_d  = '0;
    end else if (!mon_io.enable) begin
      // Partial window is dropped; published results stay untouched.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d    = StRun;
          len_d      = len_in;
          win_cnt_d  = '0;
          acc_sum_d  = '0;
          acc_peak_d = '0;
          acc_ovf_d  = '0;
        end
        StRun: begin
          if (terminal) begin
            sum_d      = samp_sum;
            peak_d     = samp_peak;
            ovf_cnt_d  = samp_ovf;
            done_d     = 1'b1;
            win_cnt_d  = '0;
            acc_sum_d  = '0;
            acc_peak_d = '0;
            acc_ovf_d  = '0;
            if (mon_io.oneshot) begin
              state_d = StDone;
            end else begin
              len_d = len_in;
            end
          end else begin
            win_cnt_d  = win_cnt_q + WIN_WIDTH'(1);
            acc_sum_d  = samp_sum;
            acc_peak_d = samp_peak;
            acc_ovf_d  = samp_ovf;
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      len_q      <= WIN_WIDTH'(1);
      win_cnt_q  <= '0;
      acc_sum_q  <= '0;
      acc_peak_q <= '0;
      acc_ovf_q  <= '0;
      sum_q      <= '0;
      peak_q     <= '0;
      ovf_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= mon_io.cnt;
      ovf_q      <= mon_io.overflow;
      len_q      <= len_d;
      win_cnt_q  <= win_cnt_d;
      acc_sum_q  <= acc_sum_d;
      acc_peak_q <= acc_peak_d;
      acc_ovf_q  <= acc_ovf_d;
      sum_q      <= sum_d;
      peak_q     <= peak_d;
      ovf_cnt_q  <= ovf_cnt_d;
      done_q     <= done_d;
    end
  end

  assign mon_io.sum     = sum_q;
  assign mon_io.peak    = peak_q;
  assign mon_io.ovf_cnt = ovf_cnt_q;
  assign mon_io.done    = done_q;
  assign mon_io.busy    = (state_q == StRun);

endmodule
